// File: rtl/wb_port_arbiter_if.sv
// Writeback request and register-file write-port bundle for wb_port_arbiter.
// The arbiter connects through the slave modport; requesters and the register file use master.
interface wb_port_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 6
) ();

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]                 req_ready;

  logic                  write_En;
  logic [ADDR_WIDTH-1:0] write_Addr;
  logic [DATA_WIDTH-1:0] write_Data;
  logic                  write_En_2;
  logic [ADDR_WIDTH-1:0] write_Addr_2;
  logic [DATA_WIDTH-1:0] write_Data_2;

  logic [31:0] stat_grant_cnt;
  logic [31:0] stat_conflict_cnt;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready,
    input  write_En, write_Addr, write_Data,
    input  write_En_2, write_Addr_2, write_Data_2,
    input  stat_grant_cnt, stat_conflict_cnt
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready,
    output write_En, write_Addr, write_Data,
    output write_En_2, write_Addr_2, write_Data_2,
    output stat_grant_cnt, stat_conflict_cnt
  );

endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin writeback arbiter driving two register-file write ports; x0 writes are dropped.
// Define WB_ARB_STATS_EN to build the saturating grant/conflict counters.
module wb_port_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input logic              clk,
  input logic              rst,
  wb_port_arbiter_if.slave wb_if
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]    cand;
  logic [NUM_REQ-1:0]    zero_addr;
  logic [NUM_REQ-1:0]    req_ready_c;
  logic                  a_vld, b_vld, defer;
  logic [PTR_W-1:0]      a_idx, b_idx;

  logic                  write_en_q,    write_en_d;
  logic [ADDR_WIDTH-1:0] write_addr_q,  write_addr_d;
  logic [DATA_WIDTH-1:0] write_data_q,  write_data_d;
  logic                  write_en2_q,   write_en2_d;
  logic [ADDR_WIDTH-1:0] write_addr2_q, write_addr2_d;
  logic [DATA_WIDTH-1:0] write_data2_q, write_data2_d;

  // Split valid requests into discarded x0 writes and real candidates.
  always_comb begin
    zero_addr = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      zero_addr[i] = wb_if.req_valid[i] && (wb_if.req_addr[i] == '0);
      cand[i]      = wb_if.req_valid[i] && (wb_if.req_addr[i] != '0);
    end
  end

  // Scan from rr_ptr: first candidate is A, next one with a different address is B.
  always_comb begin : scan_comb
    logic [PTR_W-1:0] cur;
    cur   = '0;
    a_vld = 1'b0;
    a_idx = '0;
    b_vld = 1'b0;
    b_idx = '0;
    defer = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cur = PTR_W'((32'(rr_ptr_q) + 32'(k)) % NUM_REQ);
      if (cand[cur]) begin
        if (!a_vld) begin
          a_vld = 1'b1;
          a_idx = cur;
        end else if (!b_vld) begin
          if (wb_if.req_addr[cur] == wb_if.req_addr[a_idx]) begin
            defer = 1'b1;
          end else begin
            b_vld = 1'b1;
            b_idx = cur;
          end
        end
      end
    end
  end

  // Handshake is held off entirely while reset is asserted.
  always_comb begin
    req_ready_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready_c[i] = !rst && (zero_addr[i] ||
                                (a_vld && (a_idx == PTR_W'(i))) ||
                                (b_vld && (b_idx == PTR_W'(i))));
    end
  end

  always_comb begin : ptr_comb
    logic [PTR_W-1:0] last;
    last     = b_vld ? b_idx : a_idx;
    rr_ptr_d = rr_ptr_q;
    if (a_vld) begin
      rr_ptr_d = ((32'(last) + 32'd1) == NUM_REQ) ? '0 : last + PTR_W'(1);
    end
  end

  always_comb begin
    write_en_d    = a_vld;
    write_addr_d  = a_vld ? wb_if.req_addr[a_idx] : '0;
    write_data_d  = a_vld ? wb_if.req_data[a_idx] : '0;
    write_en2_d   = b_vld;
    write_addr2_d = b_vld ? wb_if.req_addr[b_idx] : '0;
    write_data2_d = b_vld ? wb_if.req_data[b_idx] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q      <= '0;
      write_en_q    <= 1'b0;
      write_addr_q  <= '0;
      write_data_q  <= '0;
      write_en2_q   <= 1'b0;
      write_addr2_q <= '0;
      write_data2_q <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      write_en_q    <= write_en_d;
      write_addr_q  <= write_addr_d;
      write_data_q  <= write_data_d;
      write_en2_q   <= write_en2_d;
      write_addr2_q <= write_addr2_d;
      write_data2_q <= write_data2_d;
    end
  end

  assign wb_if.req_ready    = req_ready_c;
  assign wb_if.write_En     = write_en_q;
  assign wb_if.write_Addr   = write_addr_q;
  assign wb_if.write_Data   = write_data_q;
  assign wb_if.write_En_2   = write_en2_q;
  assign wb_if.write_Addr_2 = write_addr2_q;
  assign wb_if.write_Data_2 = write_data2_q;

`ifdef WB_ARB_STATS_EN
  logic [31:0] grant_cnt_q;
  logic [31:0] conflict_cnt_q;
  logic [32:0] grant_sum;

  assign grant_sum = {1'b0, grant_cnt_q} + 33'(a_vld) + 33'(b_vld);

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt_q    <= '0;
      conflict_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_sum[32] ? '1 : grant_sum[31:0];
      if (defer && (conflict_cnt_q != '1)) begin
        conflict_cnt_q <= conflict_cnt_q + 32'd1;
      end
    end
  end

  assign wb_if.stat_grant_cnt    = grant_cnt_q;
  assign wb_if.stat_conflict_cnt = conflict_cnt_q;
`else
  logic unused_defer;
  assign unused_defer            = defer;
  assign wb_if.stat_grant_cnt    = '0;
  assign wb_if.stat_conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed and randomized self-checking bench for wb_port_arbiter (NUM_REQ=4).
// Counter expectations follow WB_ARB_STATS_EN when defined.
module tb_wb_port_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DW      = 32;
  localparam int unsigned AW      = 6;
`ifdef WB_ARB_STATS_EN
  localparam int unsigned STATS_ON = 1;
`else
  localparam int unsigned STATS_ON = 0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  wb_port_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) wb_if ();

  wb_port_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst   (rst),
    .wb_if (wb_if)
  );

  int n_checks = 0;
  int n_errors = 0;
  int total_wr = 0;
  logic [31:0] seqn [NUM_REQ];
  logic [AW-1:0] outst [logic [31:0]];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [3:0] v,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [AW-1:0] a2, input logic [AW-1:0] a3,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                         input logic [DW-1:0] d2, input logic [DW-1:0] d3);
    wb_if.req_valid   = v;
    wb_if.req_addr[0] = a0;
    wb_if.req_addr[1] = a1;
    wb_if.req_addr[2] = a2;
    wb_if.req_addr[3] = a3;
    wb_if.req_data[0] = d0;
    wb_if.req_data[1] = d1;
    wb_if.req_data[2] = d2;
    wb_if.req_data[3] = d3;
  endtask

  // One random cycle: optionally issue, record handshakes, then score the write ports.
  task automatic rnd_cycle(input bit issue);
    bit              drop [NUM_REQ];
    int              acc_cnt;
    logic [DW-1:0]   d;
    bit              hit;
    acc_cnt = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      drop[i] = 1'b0;
      if (issue && !wb_if.req_valid[i] && ($urandom_range(0, 99) < 60)) begin
        wb_if.req_valid[i] = 1'b1;
        wb_if.req_addr[i]  = AW'($urandom_range(0, 7));
        wb_if.req_data[i]  = {8'(i), 24'(seqn[i])};
        seqn[i]++;
      end
    end
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (wb_if.req_valid[i] && wb_if.req_ready[i]) begin
        drop[i] = 1'b1;
        if (wb_if.req_addr[i] != '0) begin
          outst[wb_if.req_data[i]] = wb_if.req_addr[i];
          acc_cnt++;
        end
      end
    end
    tick();
    check("rnd_nwr", 64'(wb_if.write_En) + 64'(wb_if.write_En_2), 64'(acc_cnt));
    if (wb_if.write_En) begin
      d   = wb_if.write_Data;
      hit = outst.exists(d);
      check("rnd_p1_hit", 64'(hit), 64'd1);
      if (hit) begin
        check("rnd_p1_addr", 64'(wb_if.write_Addr), 64'(outst[d]));
        outst.delete(d);
      end
      total_wr++;
    end
    if (wb_if.write_En_2) begin
      d   = wb_if.write_Data_2;
      hit = outst.exists(d);
      check("rnd_p2_hit", 64'(hit), 64'd1);
      if (hit) begin
        check("rnd_p2_addr", 64'(wb_if.write_Addr_2), 64'(outst[d]));
        outst.delete(d);
      end
      total_wr++;
    end
    if (wb_if.write_En && wb_if.write_En_2) begin
      check("rnd_collide", 64'(wb_if.write_Addr == wb_if.write_Addr_2), 64'd0);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (drop[i]) wb_if.req_valid[i] = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    set_all(4'b0000, '0, '0, '0, '0, '0, '0, '0, '0);
    for (int i = 0; i < NUM_REQ; i++) seqn[i] = '0;
    tick();
    tick();
    check("rst_en", {wb_if.write_En, wb_if.write_En_2}, 64'd0);
    rst = 1'b0;

    // Idle after reset release
    for (int c = 0; c < 10; c++) begin
      #1;
      check("idle_rdy", 64'(wb_if.req_ready), 64'd0);
      tick();
      check("idle_ctl", {wb_if.write_En, wb_if.write_En_2, wb_if.write_Addr, wb_if.write_Addr_2}, 64'd0);
      check("idle_data", {wb_if.write_Data, wb_if.write_Data_2}, 64'd0);
    end

    // Fair rotation over four distinct addresses held continuously
    set_all(4'b1111, 6'd5, 6'd6, 6'd7, 6'd8, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
    #1;
    check("rot1_rdy", 64'(wb_if.req_ready), 64'b0011);
    tick();
    check("rot1_en", {wb_if.write_En, wb_if.write_En_2}, 64'b11);
    check("rot1_addr", {wb_if.write_Addr, wb_if.write_Addr_2}, {6'd5, 6'd6});
    check("rot1_data", {wb_if.write_Data, wb_if.write_Data_2}, {32'hA0, 32'hA1});
    #1;
    check("rot2_rdy", 64'(wb_if.req_ready), 64'b1100);
    tick();
    check("rot2_addr", {wb_if.write_Addr, wb_if.write_Addr_2}, {6'd7, 6'd8});
    check("rot2_data", {wb_if.write_Data, wb_if.write_Data_2}, {32'hA2, 32'hA3});
    #1;
    check("rot3_rdy", 64'(wb_if.req_ready), 64'b0011);
    tick();
    check("rot3_addr", {wb_if.write_Addr, wb_if.write_Addr_2}, {6'd5, 6'd6});
    wb_if.req_valid = '0;
    tick();
    check("rot_idle_en", {wb_if.write_En, wb_if.write_En_2}, 64'd0);

    // x0 write: accepted immediately, discarded, pointer untouched
    wb_if.req_valid   = 4'b0010;
    wb_if.req_addr[1] = 6'd0;
    wb_if.req_data[1] = 32'hDEAD;
    #1;
    check("x0_rdy", 64'(wb_if.req_ready), 64'b0010);
    tick();
    check("x0_en", {wb_if.write_En, wb_if.write_En_2}, 64'd0);

    // Pointer still at 2, so requesters 2 and 3 win first
    set_all(4'b1111, 6'd5, 6'd6, 6'd7, 6'd8, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
    #1;
    check("ptr_rdy", 64'(wb_if.req_ready), 64'b1100);
    tick();
    check("ptr_addr", {wb_if.write_Addr, wb_if.write_Addr_2}, {6'd7, 6'd8});
    wb_if.req_valid = '0;

    // Same-address deferral
    set_all(4'b0111, 6'd9, 6'd9, 6'd3, 6'd0, 32'h10, 32'h11, 32'h12, 32'h0);
    #1;
    check("cf1_rdy", 64'(wb_if.req_ready), 64'b0101);
    tick();
    check("cf1_en", {wb_if.write_En, wb_if.write_En_2}, 64'b11);
    check("cf1_addr", {wb_if.write_Addr, wb_if.write_Addr_2}, {6'd9, 6'd3});
    check("cf1_data", {wb_if.write_Data, wb_if.write_Data_2}, {32'h10, 32'h12});
    wb_if.req_valid = 4'b0010;
    #1;
    check("cf2_rdy", 64'(wb_if.req_ready), 64'b0010);
    tick();
    check("cf2_en", {wb_if.write_En, wb_if.write_En_2}, 64'b10);
    check("cf2_addr", 64'(wb_if.write_Addr), 64'd9);
    check("cf2_data", 64'(wb_if.write_Data), 64'h11);
    check("stat_conflict", 64'(wb_if.stat_conflict_cnt), 64'(STATS_ON));
    check("stat_grant", 64'(wb_if.stat_grant_cnt), 64'(STATS_ON * 11));
    wb_if.req_valid = '0;

    // Reset mid-operation with three requesters waiting
    set_all(4'b0111, 6'd1, 6'd2, 6'd3, 6'd0, 32'h21, 32'h22, 32'h23, 32'h0);
    rst = 1'b1;
    #1;
    check("rstm_rdy", 64'(wb_if.req_ready), 64'd0);
    tick();
    check("rstm_en", {wb_if.write_En, wb_if.write_En_2}, 64'd0);
    check("rstm_stats", {wb_if.stat_grant_cnt, wb_if.stat_conflict_cnt}, 64'd0);
    rst = 1'b0;
    #1;
    check("rstm_rdy2", 64'(wb_if.req_ready), 64'b0011);
    tick();
    check("rstm_addr", {wb_if.write_Addr, wb_if.write_Addr_2}, {6'd1, 6'd2});
    check("rstm_data", {wb_if.write_Data, wb_if.write_Data_2}, {32'h21, 32'h22});
    wb_if.req_valid = '0;
    tick();

    // Random traffic against a reference of accepted writes, then drain
    for (int c = 0; c < 10000; c++) rnd_cycle(1'b1);
    for (int c = 0; c < 20; c++) rnd_cycle(1'b0);
    check("drain_valid", 64'(wb_if.req_valid), 64'd0);
    check("drain_outst", 64'(outst.num()), 64'd0);
    check("rnd_stat_grant", 64'(wb_if.stat_grant_cnt), 64'(STATS_ON * (2 + total_wr)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
